// File: rtl/adder_rr_scheduler.sv
// rtl/adder_rr_scheduler.sv - round-robin scheduler sharing one adder_array among four requesters
//
// Purpose: arbitrates NUM_REQ requesters onto a single combinational adder_array.
//   One transaction takes three states: IDLE (accept), EXEC (drive the array lane and
//   capture its result), and RESP (hold the registered result until the requester takes it).
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid/ready/ain/bin   per-requester operand handshake, lane i at [32i+31:32i]
//   resp_valid/ready          per-requester result handshake
//   resp_data/resp_overflow   result and overflow for the requester whose resp_valid is high
//   arr_cmd                   array lane select, 4 = idle
//   arr_ain/arr_bin           array operands, only the granted lane is non-zero in EXEC
//   arr_dout/arr_overflow     array results
//   op_count                  completed transactions, wraps at 16 bits
module adder_rr_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_ain,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_bin,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_overflow,
  output logic [2:0]                    arr_cmd,
  output logic [NUM_REQ*DATA_WIDTH-1:0] arr_ain,
  output logic [NUM_REQ*DATA_WIDTH-1:0] arr_bin,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] arr_dout,
  input  logic [NUM_REQ-1:0]            arr_overflow,
  output logic [15:0]                   op_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_ovf_q, res_ovf_d;
  logic [15:0]           op_count_q, op_count_d;

  logic [DATA_WIDTH-1:0] ain_lane  [NUM_REQ];
  logic [DATA_WIDTH-1:0] bin_lane  [NUM_REQ];
  logic [DATA_WIDTH-1:0] dout_lane [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign ain_lane[i]  = req_ain[i*DATA_WIDTH +: DATA_WIDTH];
    assign bin_lane[i]  = req_bin[i*DATA_WIDTH +: DATA_WIDTH];
    assign dout_lane[i] = arr_dout[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: first valid requester at or after rr_ptr. The index sum wraps
  // naturally because NUM_REQ is a power of two.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  always_comb begin : rr_pick
    logic [IDX_W-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr_q + IDX_W'(k);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    res_data_d    = res_data_q;
    res_ovf_d     = res_ovf_q;
    op_count_d    = op_count_q;
    req_ready     = '0;
    resp_valid    = '0;
    resp_data     = '0;
    resp_overflow = 1'b0;
    arr_cmd       = 3'd4;
    arr_ain       = '0;
    arr_bin       = '0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          // The accept is combinational, so reset must also mask it while rstn is low.
          req_ready[win_idx] = rstn;
          grant_d            = win_idx;
          op_a_d             = ain_lane[win_idx];
          op_b_d             = bin_lane[win_idx];
          state_d            = EXEC;
        end
      end
      EXEC: begin
        arr_cmd = 3'(grant_q);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == IDX_W'(i)) begin
            arr_ain[i*DATA_WIDTH +: DATA_WIDTH] = op_a_q;
            arr_bin[i*DATA_WIDTH +: DATA_WIDTH] = op_b_q;
          end
        end
        res_data_d = dout_lane[grant_q];
        res_ovf_d  = arr_overflow[grant_q];
        state_d    = RESP;
      end
      RESP: begin
        resp_valid[grant_q] = 1'b1;
        resp_data           = res_data_q;
        resp_overflow       = res_ovf_q;
        // Only the granted requester's resp_ready can close the transaction.
        if (resp_ready[grant_q]) begin
          rr_ptr_d   = grant_q + IDX_W'(1);
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;

endmodule
